// File: rtl/soc_pkg.sv
// soc_pkg: register word offsets, STATUS bit indices and transmitter FSM states shared by the UART slice
package soc_pkg;
  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: core data bus (r read request, w byte strobes, addr, in write data, out read data)
interface mmio_uart_tx_if;
  logic r;
  logic [3:0] w;
  logic [31:0] addr;
  logic [31:0] in;
  logic [31:0] out;
  modport master(output r, w, addr, in, input out);
  modport slave(input r, w, addr, in, output out);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: zero-latency FIFO; ports clk, rst, push/din, pop/dout, full, empty, count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter; ports clk, rst, bus (slave data bus), tx serial line
module mmio_uart_tx
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_1000,
  parameter int FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET = 16'd4
) (
  input  logic clk,
  input  logic rst,
  mmio_uart_tx_if.slave bus,
  output logic tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_tx_state_t state;
  logic sel, wr_data, pop, full, empty, ovf, bit_end, unused_bits;
  logic [1:0] off;
  logic [15:0] div, bit_len, cnt;
  logic [7:0] shift, head;
  logic [2:0] bit_idx;
  logic [CW-1:0] count;
  logic [31:0] status;
  assign sel = bus.addr[31:4] == BASE[31:4];
  assign off = bus.addr[3:2];
  assign wr_data = sel && off == OFF_DATA && bus.w[0] && !rst;
  assign bit_len = div == '0 ? 16'd1 : div;
  assign bit_end = cnt == '0;
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  assign tx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign unused_bits = ^{bus.addr[1:0], bus.in[31:16], bus.w[3:2], count};
  always_comb begin
    status = '0;
    status[ST_BUSY] = state != IDLE;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
  end
  assign bus.out = !(sel && bus.r) ? '0 : off == OFF_STATUS ? status : off == OFF_DIV ? {16'b0, div} : '0;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(wr_data),
    .pop(pop),
    .din(bus.in[7:0]),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bit_idx <= '0;
      cnt <= '0;
      div <= DIV_RESET;
      ovf <= 1'b0;
    end else begin
      if (sel && off == OFF_DIV && bus.w[0]) div[7:0] <= bus.in[7:0];
      if (sel && off == OFF_DIV && bus.w[1]) div[15:8] <= bus.in[15:8];
      if (wr_data && full && !pop) ovf <= 1'b1;
      else if (sel && off == OFF_STATUS && bus.w[0] && bus.in[3]) ovf <= 1'b0;
      if (pop) begin
        shift <= head;
        bit_idx <= '0;
        cnt <= bit_len - 16'd1;
        state <= START;
      end else if (state != IDLE) begin
        cnt <= bit_end ? bit_len - 16'd1 : cnt - 16'd1;
        if (bit_end && state == START) state <= DATA;
        if (bit_end && state == DATA) begin
          shift <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        if (bit_end && state == STOP) state <= IDLE;
      end
    end
  end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_1000, the 16-byte-aligned base address of the register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter DIV_RESET, default 16'd4, the reset value of DIVISOR.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port r, input, 1 bit: data-bus read request from the core.
REQ-007 SHALL have port w, input, 4 bits: data-bus byte write strobes; w[i] enables in[8i+7:8i].
REQ-008 SHALL have port addr, input, 32 bits: data-bus byte address.
REQ-009 SHALL have port in, input, 32 bits: data-bus write data.
REQ-010 SHALL have port out, input... no: out, output, 32 bits: read data, combinational.
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-012 SHALL decode sel = (addr[31:4] == BASE[31:4]); offsets are taken from addr[3:2]; addr[1:0] are ignored.
REQ-013 SHALL provide these registers: 0x0 DATA (write-only), 0x4 STATUS (read/write), 0x8 DIVISOR (read/write, bits 15:0), 0xC reserved (reads 0, writes ignored).
REQ-014 SHALL drive out to 0 whenever sel=0 or r=0, so that out can be OR-combined with other responders.
REQ-015 SHALL return, on a STATUS read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits 31:4 zero.
REQ-016 SHALL push in[7:0] into the FIFO on a clock edge where sel, offset 0x0, and w[0]=1; w[3:1] are ignored.
REQ-017 SHALL accept a push when count<FIFO_DEPTH, or when a pop occurs on the same edge; otherwise it SHALL drop the byte and set overflow.
REQ-018 SHALL clear overflow on a STATUS write with w[0]=1 and in[3]=1.
REQ-019 SHALL update DIVISOR bytes per w[1:0]; a DIVISOR value of 0 SHALL behave as 1.
REQ-020 SHALL run FSM states IDLE, START, DATA, STOP, with every bit lasting exactly max(DIVISOR,1) cycles.
REQ-021 IDLE: tx=1; if the FIFO is non-empty, pop the head into the shift register and go to START.
REQ-022 START: tx=0 for one bit time, then go to DATA with bit index 0.
REQ-023 DATA: tx=shift[0], LSB first; after each bit time, shift right; after bit 7, go to STOP.
REQ-024 STOP: tx=1 for one bit time; then pop the next byte directly into START if the FIFO is non-empty, otherwise go to IDLE.
REQ-025 Latency: for a DATA write captured at edge N while IDLE with the FIFO empty, the byte SHALL pop at edge N+1 and tx SHALL go low after edge N+1.
REQ-026 SHALL sample DIVISOR at the start of each bit time; a DIVISOR write mid-bit SHALL take effect at the next bit.
REQ-027 Simultaneous r and w to the same register: reads SHALL return the pre-edge value.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL reach these values: FSM=IDLE, tx=1, FIFO empty (pointers=0, count=0), overflow=0, DIVISOR=DIV_RESET, bit counter and shift register=0.
REQ-029 A reset asserted mid-frame SHALL abort the frame, drive tx=1 the following cycle, and discard queued bytes.
REQ-030 While rst=1, bus writes SHALL be ignored.

Structure
REQ-031 soc_pkg SHALL hold the register offsets, STATUS bit indices, and the FSM state enum (uart_tx_state_t).
REQ-032 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) with registered storage and no read latency.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Verification
REQ-034 Reset, then DIVISOR=4, write DATA=0x55 -> tx: 4 cycles low, bits 1,0,1,0,1,0,1,0 at 4 cycles each, 4 cycles high; busy=1 throughout the frame, then empty=1.
REQ-035 Write 0xA5, 0x3C back-to-back -> the two frames are contiguous (STOP followed directly by START), totalling 80 cycles.
REQ-036 With tx busy, write 6 bytes at depth 4 -> the first byte is in flight, 4 are queued, and the 6th is dropped; STATUS=0x0B (busy, full, overflow); a STATUS write of 0x8 then clears overflow.
REQ-037 Read with addr=BASE+0x20 or r=0 -> out=0; read BASE+0x8 after reset -> 0x0000_0004.
REQ-038 Assert rst during DATA bit 3 -> next cycle tx=1, STATUS=0x4, and no further transitions occur.
REQ-039 DIVISOR=0, write 0xFF -> frame lasts 10 cycles (1 cycle per bit).
